// File: rtl/mmio_defs.sv
// Shared definitions for the MMIO bridge: peripheral register offsets, UART_STATUS
// bit positions, UART TX state encoding and the baud-divisor clamp.
package mmio_defs;

  localparam logic [1:0] OFF_UART_DATA   = 2'd0;
  localparam logic [1:0] OFF_UART_STATUS = 2'd1;
  localparam logic [1:0] OFF_CYCLE_COUNT = 2'd2;
  localparam logic [1:0] OFF_CLK_DIV     = 2'd3;

  localparam int STAT_FULL    = 0;
  localparam int STAT_EMPTY   = 1;
  localparam int STAT_BUSY    = 2;
  localparam int STAT_OVF     = 3;
  localparam int STAT_CNT_LSB = 8;

  localparam logic [15:0] CLK_DIV_MIN = 16'd2;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

  function automatic logic [15:0] clamp_div(input logic [15:0] div);
    return (div < CLK_DIV_MIN) ? CLK_DIV_MIN : div;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: a power-of-two byte FIFO feeding a START/DATA/STOP
// shift FSM. The bit period is sampled from i_div each time a byte is popped.
module uart_tx_fifo
  import mmio_defs::*;
#(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_push,
  input  logic [7:0]  i_data,
  input  logic [15:0] i_div,
  output logic        o_full,
  output logic        o_empty,
  output logic [AW:0] o_count,
  output logic        o_busy,
  output logic        o_drop,
  output logic        o_tx
);

  logic [7:0]  r_mem [DEPTH];
  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  tx_state_e   r_state;
  logic [7:0]  r_shift;
  logic [2:0]  r_bit_cnt;
  logic [15:0] r_div;
  logic [15:0] r_div_cnt;
  logic        r_tx;

  logic w_bit_done;
  logic w_pop;
  logic w_push_ok;

  // Pointers carry one extra wrap bit, so the difference is the occupancy.
  assign o_count    = r_wr_ptr - r_rd_ptr;
  assign o_full     = o_count[AW];
  assign o_empty    = (r_wr_ptr == r_rd_ptr);
  assign w_bit_done = (r_div_cnt == 16'd0);
  assign w_pop      = !o_empty && ((r_state == TX_IDLE) || ((r_state == TX_STOP) && w_bit_done));
  assign w_push_ok  = i_push && (!o_full || w_pop);
  assign o_drop     = i_push && !w_push_ok;
  assign o_busy     = (r_state != TX_IDLE);
  assign o_tx       = r_tx;

  // NOTE: the payload array is deliberately not reset; validity is tracked by the pointers alone.
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_wr_ptr <= '0;
    else if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= TX_IDLE;
      r_rd_ptr  <= '0;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_div     <= CLK_DIV_MIN;
      r_div_cnt <= '0;
      r_tx      <= 1'b1;
    end else if (w_pop) begin
      r_rd_ptr  <= r_rd_ptr + 1'b1;
      r_shift   <= r_mem[r_rd_ptr[AW-1:0]];
      r_div     <= i_div;
      r_div_cnt <= i_div - 16'd1;
      r_state   <= TX_START;
      r_tx      <= 1'b0;
    end else begin
      case (r_state)
        TX_IDLE: r_tx <= 1'b1;
        TX_START: begin
          if (w_bit_done) begin
            r_state   <= TX_DATA;
            r_tx      <= r_shift[0];
            r_shift   <= {1'b0, r_shift[7:1]};
            r_bit_cnt <= 3'd0;
            r_div_cnt <= r_div - 16'd1;
          end else begin
            r_div_cnt <= r_div_cnt - 16'd1;
          end
        end
        TX_DATA: begin
          if (w_bit_done) begin
            r_div_cnt <= r_div - 16'd1;
            if (r_bit_cnt == 3'd7) begin
              r_state <= TX_STOP;
              r_tx    <= 1'b1;
            end else begin
              r_tx      <= r_shift[0];
              r_shift   <= {1'b0, r_shift[7:1]};
              r_bit_cnt <= r_bit_cnt + 3'd1;
            end
          end else begin
            r_div_cnt <= r_div_cnt - 16'd1;
          end
        end
        TX_STOP: begin
          if (w_bit_done) begin
            r_state <= TX_IDLE;
            r_tx    <= 1'b1;
          end else begin
            r_div_cnt <= r_div_cnt - 16'd1;
          end
        end
        default: r_state <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/mmio_bridge.sv
// Core data-port bridge: routes accesses to data RAM or to the UART/cycle-counter block
// with one-cycle read latency. Define MMIO_CYCLE_COUNTER_EN to build the cycle counter.
module mmio_bridge
  import mmio_defs::*;
#(
  parameter int          FIFO_DEPTH    = 16,
  parameter logic [15:0] CLK_DIV_RESET = 16'd434,
  parameter logic [31:0] PERIPH_BASE   = 32'hBFD0_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ram_en,
  input  logic [3:0]  ram_write_en,
  input  logic [31:0] ram_addr,
  input  logic [31:0] ram_write_data,
  output logic [31:0] ram_read_data,
  output logic        dram_en,
  output logic [3:0]  dram_write_en,
  output logic [31:0] dram_addr,
  output logic [31:0] dram_write_data,
  input  logic [31:0] dram_read_data,
  output logic        uart_tx
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic        w_hit_p;
  logic [1:0]  w_off;
  logic        w_wr;
  logic        w_rd;
  logic        w_push;
  logic        w_stat_rd;
  logic        w_div_wr;
  logic [15:0] w_div_next;
  logic [31:0] w_status;
  logic [31:0] w_cycle;
  logic [31:0] w_prd;

  logic        w_full;
  logic        w_empty;
  logic [AW:0] w_count;
  logic        w_busy;
  logic        w_drop;

  logic        r_sel;
  logic [31:0] r_prd;
  logic [15:0] r_div;
  logic        r_ovf;

  assign w_hit_p   = ram_en && (ram_addr[31:16] == PERIPH_BASE[31:16]);
  assign w_off     = ram_addr[3:2];
  assign w_wr      = w_hit_p && (ram_write_en != 4'b0000);
  assign w_rd      = w_hit_p && (ram_write_en == 4'b0000);
  assign w_push    = w_hit_p && ram_write_en[0] && (w_off == OFF_UART_DATA);
  assign w_stat_rd = w_rd && (w_off == OFF_UART_STATUS);
  assign w_div_wr  = w_wr && (w_off == OFF_CLK_DIV);

  assign dram_en         = ram_en && !w_hit_p;
  assign dram_write_en   = w_hit_p ? 4'b0000 : ram_write_en;
  assign dram_addr       = ram_addr;
  assign dram_write_data = ram_write_data;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_uart (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (ram_write_data[7:0]),
    .i_div   (r_div),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count),
    .o_busy  (w_busy),
    .o_drop  (w_drop),
    .o_tx    (uart_tx)
  );

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_div_next = r_div;
    if (ram_write_en[0]) w_div_next[7:0]  = ram_write_data[7:0];
    if (ram_write_en[1]) w_div_next[15:8] = ram_write_data[15:8];
  end

  always_comb begin
    w_status                       = '0;
    w_status[STAT_FULL]            = w_full;
    w_status[STAT_EMPTY]           = w_empty;
    w_status[STAT_BUSY]            = w_busy;
    w_status[STAT_OVF]             = r_ovf;
    w_status[STAT_CNT_LSB +: 8]    = 8'(w_count);
  end

`ifdef MMIO_CYCLE_COUNTER_EN
  logic        w_cnt_clr;
  logic [31:0] r_cycle;

  assign w_cnt_clr = w_wr && (w_off == OFF_CYCLE_COUNT);

  // A clearing write wins over the free-running increment.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_cycle <= '0;
    else if (w_cnt_clr) r_cycle <= '0;
    else r_cycle <= r_cycle + 32'd1;
  end

  assign w_cycle = r_cycle;
`else
  assign w_cycle = '0;
`endif

  always_comb begin
    w_prd = '0;
    case (w_off)
      OFF_UART_STATUS: w_prd = w_status;
      OFF_CYCLE_COUNT: w_prd = w_cycle;
      OFF_CLK_DIV:     w_prd = {16'h0000, r_div};
      default:         w_prd = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sel <= 1'b0;
      r_prd <= '0;
    end else begin
      r_sel <= w_hit_p;
      if (w_hit_p) r_prd <= w_prd;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_div <= CLK_DIV_RESET;
    else if (w_div_wr) r_div <= clamp_div(w_div_next);
  end

  // A drop in the same cycle as a status read leaves overflow set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_ovf <= 1'b0;
    else if (w_drop) r_ovf <= 1'b1;
    else if (w_stat_rd) r_ovf <= 1'b0;
  end

  assign ram_read_data = r_sel ? r_prd : dram_read_data;

endmodule
